// File: rtl/mem_access_seq.sv
// mem_access_seq: multicycle load/store/fetch sequencer between control and the memory port.
// Accepts one request at a time, drives an aligned address with lane byte enables and
// lane-shifted store data, waits for mem_resp (optionally bounded by TIMEOUT cycles) and
// returns extended load data or a trap cause, together with RVFI read/write lane masks.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake (ready only when idle)
//   req_write, req_funct3         access kind and RV load/store funct3
//   req_addr, req_wdata           byte address, unshifted store data
//   rsp_valid                     one-cycle completion pulse
//   rsp_rdata, rsp_trap           extended load data (0 for stores/traps), trap flag
//   rsp_cause                     0 none, 1 misaligned, 2 illegal funct3, 3 timeout
//   rmask, wmask                  lanes read / written, valid with rsp_valid
//   mem_address                   aligned address
//   mem_read, mem_write           strobes, held until mem_resp or timeout
//   mem_byte_enable, mem_wdata    lane enables, lane-shifted store data
//   mem_rdata, mem_resp           read data and completion from memory
module mem_access_seq #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [2:0]          req_funct3,
    input  logic [XLEN-1:0]     req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                rsp_valid,
    output logic [XLEN-1:0]     rsp_rdata,
    output logic                rsp_trap,
    output logic [1:0]          rsp_cause,
    output logic [XLEN/8-1:0]   rmask,
    output logic [XLEN/8-1:0]   wmask,
    output logic [XLEN-1:0]     mem_address,
    output logic                mem_read,
    output logic                mem_write,
    output logic [XLEN/8-1:0]   mem_byte_enable,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic [XLEN-1:0]     mem_rdata,
    input  logic                mem_resp
);

    localparam int unsigned NB      = XLEN / 8;
    localparam int unsigned OFFW    = $clog2(NB);
    localparam logic [31:0] TO_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t state, state_nxt;

    logic            write_q;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] rdata_q;
    logic            trap_q;
    logic [1:0]      cause_q;
    logic [31:0]     cnt_q;

    function automatic logic f3_illegal(input logic wr, input logic [2:0] f3);
        if (wr) begin
            if (XLEN == 32) return f3 >= 3'b011;
            return f3 >= 3'b100;
        end
        return (f3 == 3'b111) || ((XLEN == 32) && ((f3 == 3'b011) || (f3 == 3'b110)));
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [OFFW-1:0] off);
        case (f3[1:0])
            2'b01:   return off[0];
            2'b10:   return off[1:0] != 2'b00;
            2'b11:   return off != '0;
            default: return 1'b0;
        endcase
    endfunction

    logic dec_illegal, dec_misal, to_hit;
    assign dec_illegal = f3_illegal(req_write, req_funct3);
    assign dec_misal   = misaligned(req_funct3, req_addr[OFFW-1:0]);
    // TIMEOUT == 0 disables the bound entirely
    assign to_hit      = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    // Lane datapath, derived from the latched request
    logic [OFFW-1:0]   off_q;
    logic [OFFW+2:0]   shamt;
    logic [NB-1:0]     be_c;
    logic [XLEN-1:0]   wdata_sh, rdata_sh, size_mask, load_ext;
    logic              sign_bit;

    assign off_q    = addr_q[OFFW-1:0];
    assign shamt    = {off_q, 3'b000};
    assign wdata_sh = wdata_q << shamt;
    assign rdata_sh = mem_rdata >> shamt;

    always_comb begin
        be_c      = '1;
        size_mask = '1;
        sign_bit  = 1'b0;
        case (f3_q[1:0])
            2'b00: begin
                be_c      = NB'(1) << off_q;
                size_mask = XLEN'(8'hFF);
                sign_bit  = rdata_sh[7];
            end
            2'b01: begin
                be_c      = NB'(2'b11) << off_q;
                size_mask = XLEN'(16'hFFFF);
                sign_bit  = rdata_sh[15];
            end
            2'b10: begin
                be_c      = NB'(4'hF) << off_q;
                size_mask = XLEN'(32'hFFFF_FFFF);
                sign_bit  = rdata_sh[31];
            end
            default: ;
        endcase
        // Sign extension fills everything above the access size; funct3[2] marks unsigned
        load_ext = (rdata_sh & size_mask) | ((sign_bit && !f3_q[2]) ? ~size_mask : '0);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (dec_illegal || dec_misal) state_nxt = S_RESP;
                    else                          state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (mem_resp || to_hit) state_nxt = S_RESP;
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request latch, wait counter and response capture
    always_ff @(posedge clk) begin
        if (rst) begin
            write_q <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            trap_q  <= 1'b0;
            cause_q <= '0;
            cnt_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        rdata_q <= '0;
                        cnt_q   <= '0;
                        trap_q  <= dec_illegal || dec_misal;
                        // Illegal funct3 outranks misalignment
                        cause_q <= dec_illegal ? 2'd2 : (dec_misal ? 2'd1 : 2'd0);
                    end
                end
                S_ACCESS: begin
                    // A response arriving on the last allowed cycle still completes normally
                    if (mem_resp) begin
                        rdata_q <= load_ext;
                    end else if (to_hit) begin
                        trap_q  <= 1'b1;
                        cause_q <= 2'd3;
                    end else begin
                        cnt_q   <= cnt_q + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        req_ready       = 1'b0;
        rsp_valid       = 1'b0;
        rsp_rdata       = '0;
        rsp_trap        = 1'b0;
        rsp_cause       = '0;
        rmask           = '0;
        wmask           = '0;
        mem_address     = '0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = '0;
        mem_wdata       = '0;
        case (state)
            S_IDLE: req_ready = 1'b1;
            S_ACCESS: begin
                mem_read        = !write_q;
                mem_write       = write_q;
                mem_address     = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};
                mem_byte_enable = be_c;
                mem_wdata       = wdata_sh;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_trap  = trap_q;
                rsp_cause = cause_q;
                if (!trap_q) begin
                    if (write_q) begin
                        wmask = be_c;
                    end else begin
                        rmask     = be_c;
                        rsp_rdata = rdata_q;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule
